ps2_host_sender: RTL and testbench



---
 rtl/ps2_host_sender.sv | 98 +++++++++
 tb/tb_ps2_host_sender.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/ps2_host_sender.sv
// ps2_host_sender: PS/2 host-to-device command byte transmitter with ACK check and timeouts
module ps2_host_sender #(
  parameter logic [15:0] inhibit_cycles = 16'd1500,
  parameter logic [23:0] start_timeout = 24'd215000,
  parameter logic [15:0] bit_timeout = 16'd2000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       device_clock,
  input  logic       device_data,
  output logic       drive_clock_low,
  output logic       drive_data_low,
  input  logic       send_request,
  input  logic [7:0] send_data,
  output logic       busy,
  output logic       done,
  output logic       error
);
  localparam logic [2:0] s_idle = 3'd0, s_inhibit = 3'd1, s_start = 3'd2, s_request = 3'd3,
                         s_send = 3'd4, s_wait_ack = 3'd5, s_wait_release = 3'd6, s_fail = 3'd7;
  logic [2:0] state;
  logic [2:0] clk_sync;
  logic [1:0] dat_sync;
  logic [23:0] count;
  logic [3:0] bit_count;
  logic [7:0] byte_q;
  logic parity, ack_err, data_low, fall, released, bit_expired;
  assign fall = clk_sync[2] & ~clk_sync[1];
  assign released = clk_sync[1] & dat_sync[1];
  assign bit_expired = count == {8'd0, bit_timeout - 16'd1};
  assign drive_clock_low = state == s_inhibit || state == s_start;
  assign drive_data_low = state == s_start || state == s_request || (state == s_send && data_low);
  assign busy = state != s_idle;
  assign done = state == s_fail || (state == s_wait_release && released);
  assign error = state == s_fail || (done && ack_err);
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_sync <= 3'b111;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[1:0], device_clock};
      dat_sync <= {dat_sync[0], device_data};
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= s_idle;
      count <= '0;
      bit_count <= '0;
      byte_q <= '0;
      parity <= 1'b0;
      ack_err <= 1'b0;
      data_low <= 1'b0;
    end else begin
      count <= count + 24'd1;
      case (state)
        s_idle: begin
          count <= '0;
          if (send_request) begin
            byte_q <= send_data;
            parity <= ~^send_data;
            bit_count <= '0;
            ack_err <= 1'b0;
            state <= s_inhibit;
          end
        end
        s_inhibit: if (count == {8'd0, inhibit_cycles - 16'd1}) begin
          count <= '0;
          state <= s_start;
        end
        s_start: begin
          count <= '0;
          state <= s_request;
        end
        s_request: if (fall) begin
          data_low <= ~byte_q[0];
          bit_count <= 4'd1;
          count <= 24'd1;
          state <= s_send;
        end else if (count == start_timeout - 24'd1) state <= s_fail;
        s_send: if (fall) begin
          data_low <= bit_count < 4'd8 ? ~byte_q[bit_count[2:0]] : bit_count == 4'd8 && ~parity;
          bit_count <= bit_count + 4'd1;
          count <= 24'd1;
          if (bit_count == 4'd9) state <= s_wait_ack;
        end else if (bit_expired) state <= s_fail;
        s_wait_ack: if (fall) begin
          ack_err <= dat_sync[1];
          count <= 24'd1;
          state <= s_wait_release;
        end else if (bit_expired) state <= s_fail;
        s_wait_release: if (released) state <= s_idle;
          else if (bit_expired) state <= s_fail;
        default: state <= s_idle;
      endcase
    end
  end
endmodule

// File: tb/tb_ps2_host_sender.sv
// tb_ps2_host_sender: device-model bench for the PS/2 host command sender
module tb_ps2_host_sender;
  logic clk = 1'b0, reset = 1'b1, dev_clk = 1'b1, dev_data = 1'b1, send_request = 1'b0;
  logic [7:0] send_data = 8'h00;
  logic line_clk, line_data, drive_clock_low, drive_data_low, busy, done, error;
  int vectors = 0, miscompares = 0, cyc = 0, done_count = 0;
  typedef struct {
    logic [7:0] data;
    logic       nack;
    logic [9:0] frame;
    logic       err;
  } vec_t;
  vec_t tbl[5];
  assign line_clk = dev_clk & ~drive_clock_low;
  assign line_data = dev_data & ~drive_data_low;
  ps2_host_sender #(.inhibit_cycles(16'd16), .start_timeout(24'd200), .bit_timeout(16'd100)) dut (
    .clock(clk), .reset(reset), .device_clock(line_clk), .device_data(line_data),
    .drive_clock_low(drive_clock_low), .drive_data_low(drive_data_low),
    .send_request(send_request), .send_data(send_data),
    .busy(busy), .done(done), .error(error)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done) done_count <= done_count + 1;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [9:0] model_frame(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return {1'b1, ones % 2 == 0, b};
  endfunction
  task automatic xfer(input logic [7:0] b, input int nf, input logic nack, input logic extra,
                      output logic [9:0] frame, output logic err, output int lat);
    int k, n, c0;
    logic last_dl;
    frame = '0;
    err = 1'b0;
    last_dl = 1'b0;
    send_request = 1'b1;
    send_data = b;
    @(negedge clk);
    send_request = 1'b0;
    check("busy_on_accept", busy, 1);
    n = 0;
    k = 0;
    while (drive_clock_low && k < 100) begin
      n += drive_data_low ? 0 : 1;
      last_dl = drive_data_low;
      send_request = extra && k == 4;
      send_data = (extra && k == 4) ? 8'h55 : b;
      @(negedge clk);
      k++;
    end
    send_request = 1'b0;
    check("clock_low_cycles", k, 17);
    check("inhibit_cycles", n, 16);
    check("start_bit_setup", last_dl, 1);
    check("request_data_low", drive_data_low, 1);
    c0 = cyc;
    if (nf > 0) begin
      repeat (10) @(negedge clk);
      for (int i = 1; i <= nf; i++) begin
        dev_clk = 1'b0;
        c0 = cyc;
        repeat (10) @(negedge clk);
        if (i <= 10) frame[i-1] = line_data;
        dev_clk = 1'b1;
        if (i == 10) dev_data = nack;
        if (i == 11) dev_data = 1'b1;
        if (i < nf) repeat (10) @(negedge clk);
      end
    end
    k = 0;
    while (!done && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check("done_seen", done, 1);
    lat = cyc - c0;
    err = error;
    check("busy_at_done", busy, 1);
    check("lines_released_at_done", {drive_clock_low, drive_data_low}, 0);
    @(negedge clk);
    check("busy_after_done", busy, 0);
    check("done_one_cycle", done, 0);
  endtask
  initial begin
    logic [9:0] fr;
    logic er, rn;
    logic [7:0] rb;
    int lat, dc0, k;
    tbl[0] = '{8'hED, 1'b0, 10'h3ED, 1'b0};
    tbl[1] = '{8'h00, 1'b0, 10'h300, 1'b0};
    tbl[2] = '{8'h01, 1'b0, 10'h201, 1'b0};
    tbl[3] = '{8'hFF, 1'b1, 10'h3FF, 1'b1};
    tbl[4] = '{8'hF3, 1'b0, 10'h3F3, 1'b0};
    repeat (3) @(negedge clk);
    check("rst_drive_clock_low", drive_clock_low, 0);
    check("rst_drive_data_low", drive_data_low, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    reset = 1'b0;
    @(negedge clk);
    for (int t = 0; t < 5; t++) begin
      dc0 = done_count;
      xfer(tbl[t].data, 11, tbl[t].nack, 1'b0, fr, er, lat);
      check($sformatf("tbl%0d_frame", t), fr, tbl[t].frame);
      check($sformatf("tbl%0d_error", t), er, tbl[t].err);
      check($sformatf("tbl%0d_done_count", t), done_count - dc0, 1);
    end
    repeat (5) @(negedge clk);
    xfer(8'hF3, 0, 1'b0, 1'b0, fr, er, lat);
    check("no_clock_error", er, 1);
    check("no_clock_latency", lat, 200);
    repeat (5) @(negedge clk);
    xfer(8'h5A, 5, 1'b0, 1'b0, fr, er, lat);
    check("stall_error", er, 1);
    check("stall_latency", lat, 102);
    repeat (5) @(negedge clk);
    dc0 = done_count;
    xfer(8'h3C, 11, 1'b0, 1'b1, fr, er, lat);
    check("busy_req_frame", fr, model_frame(8'h3C));
    check("busy_req_error", er, 0);
    repeat (30) @(negedge clk);
    check("busy_req_single_transfer", done_count - dc0, 1);
    check("busy_req_stays_idle", busy, 0);
    for (int t = 0; t < 8; t++) begin
      rb = 8'($urandom);
      rn = $urandom_range(0, 3) == 0;
      xfer(rb, 11, rn, 1'b0, fr, er, lat);
      check($sformatf("rand%0d_frame_%02h", t, rb), fr, model_frame(rb));
      check($sformatf("rand%0d_error", t), er, rn);
    end
    send_request = 1'b1;
    send_data = 8'hA5;
    @(negedge clk);
    send_request = 1'b0;
    k = 0;
    while (drive_clock_low && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("rst_seq_request", {busy, drive_data_low}, 2'b11);
    repeat (10) @(negedge clk);
    for (int i = 1; i <= 4; i++) begin
      dev_clk = 1'b0;
      repeat (10) @(negedge clk);
      if (i < 4) begin
        dev_clk = 1'b1;
        repeat (10) @(negedge clk);
      end
    end
    check("rst_seq_bit3_low", drive_data_low, 1);
    dc0 = done_count;
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_drive_clock_low", drive_clock_low, 0);
    check("mid_rst_drive_data_low", drive_data_low, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    reset = 1'b0;
    dev_clk = 1'b1;
    repeat (30) @(negedge clk);
    check("mid_rst_no_done", done_count - dc0, 0);
    check("mid_rst_idle", busy, 0);
    xfer(8'h80, 11, 1'b0, 1'b0, fr, er, lat);
    check("post_rst_frame", fr, model_frame(8'h80));
    check("post_rst_error", er, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
